// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared constants and types for the packet-level UART TX arbiter.
//   - GRANT_W : width of grant index / round-robin pointer
//   - HDR_TAG : upper nibble of the optional per-packet tag byte
//   - state_e : arbiter FSM states (IDLE, HDR, XFER)
//   - rr_next : pointer advance with wrap at the requester count
package uart_arb_pkg;

  localparam int GRANT_W = 3;

  localparam logic [3:0] HDR_TAG = 4'hA;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HDR  = ST_HDR,
    XFER = ST_XFER
  } state_e;

  // (id + 1) mod n, where n is the requester count and id < n.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] id,
                                                 input logic [GRANT_W:0]   n);
    logic [GRANT_W:0] inc;
    inc = {1'b0, id} + 1'b1;
    return (inc >= n) ? '0 : inc[GRANT_W-1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational rotate-priority encoder: finds the first set request at or
//   after the pointer, wrapping around.
//   Ports:
//     i_req   [N_REQ-1:0]   request vector
//     i_ptr   [GRANT_W-1:0] search start (must be < N_REQ)
//     o_idx   [GRANT_W-1:0] index of the selected request
//     o_found               at least one request is set
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   i_req,
  input  logic [GRANT_W-1:0] i_ptr,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_found
);

  localparam logic [GRANT_W:0] LP_N = (GRANT_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [GRANT_W:0]   w_off;
  logic [GRANT_W:0]   w_sum;

  // Rotating the doubled vector right by the pointer puts the pointer's
  // requester at bit 0, so a plain lowest-set-bit search gives the offset.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off   = (GRANT_W+1)'(j);
        o_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_ptr} + w_off;
    if (w_sum >= LP_N) begin
      w_sum = w_sum - LP_N;
    end
  end

  assign o_idx = w_sum[GRANT_W-1:0];

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Packet-level round-robin arbiter sharing one UART TX byte stream among
//   N_REQ requesters. A grant is held from a packet's first byte to its tlast
//   byte, so packets never interleave.
//   Build option: define UART_ARB_HDR_EN to prefix each packet with a tag byte
//   {HDR_TAG, 1'b0, grant_id}; undefined, only payload bytes are sent.
//   Ports:
//     clk, rst                  core clock, async active-high reset
//     s_tdata/s_tvalid/s_tlast  requester streams (requester i at [8i+7:8i])
//     s_tready                  per-requester accept
//     m_tdata/m_tvalid/m_tready registered output stream to the UART TX
//     busy                      a grant is held
//     grant_id                  current or most recent grantee
//
//   state | meaning
//   IDLE  | no grant; pick next requester from the round-robin pointer
//   HDR   | load tag byte once the output register is free (tag build only)
//   XFER  | pass grantee bytes until its tlast byte is accepted
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tvalid,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic [N_REQ-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    busy,
  output logic [GRANT_W-1:0]      grant_id
);

  localparam logic [GRANT_W:0] LP_N = (GRANT_W+1)'(N_REQ);

  state_e              r_state;
  logic [GRANT_W-1:0]  r_ptr;
  logic [GRANT_W-1:0]  r_gid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mdata;
  logic                r_mvalid;

  logic [GRANT_W-1:0]  w_idx;
  logic                w_found;
  logic                w_out_free;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic                w_accept;
  logic                w_load;
  logic [DATA_W-1:0]   w_load_data;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (s_tvalid),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // The output register can take a new byte when it is empty or being drained.
  assign w_out_free = !r_mvalid || m_tready;

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gid == GRANT_W'(i)) begin
        w_sel_data  = s_tdata[i*DATA_W +: DATA_W];
        w_sel_valid = s_tvalid[i];
        w_sel_last  = s_tlast[i];
      end
    end
  end

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s_tready[i] = (r_state == XFER) && (r_gid == GRANT_W'(i)) && w_out_free;
    end
  end

  assign w_accept = (r_state == XFER) && w_sel_valid && w_out_free;

  always_comb begin
    w_load      = 1'b0;
    w_load_data = '0;
    if (w_accept) begin
      w_load      = 1'b1;
      w_load_data = w_sel_data;
    end
`ifdef UART_ARB_HDR_EN
    if ((r_state == HDR) && w_out_free) begin
      w_load      = 1'b1;
      w_load_data = DATA_W'({HDR_TAG, 1'b0, r_gid});
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_busy   <= 1'b0;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
    end else begin
      if (w_load) begin
        r_mdata  <= w_load_data;
        r_mvalid <= 1'b1;
      end else if (m_tready) begin
        r_mvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gid  <= w_idx;
            r_busy <= 1'b1;
`ifdef UART_ARB_HDR_EN
            r_state <= HDR;
`else
            r_state <= XFER;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        HDR: begin
          if (w_out_free) begin
            r_state <= XFER;
          end
        end
`endif
        XFER: begin
          // A stalled grantee keeps the grant; only its own tlast ends it.
          if (w_accept && w_sel_last) begin
            r_ptr   <= rr_next(r_gid, LP_N);
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_tdata  = r_mdata;
  assign m_tvalid = r_mvalid;
  assign busy     = r_busy;
  assign grant_id = r_gid;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy;
  logic [2:0]  grant_id;

  int total = 0;
  int bad   = 0;

  logic [7:0] mon_q[$];

  uart_tx_arb #(
    .N_REQ  (4),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_tvalid && m_tready) mon_q.push_back(m_tdata);
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        mv;
    logic [7:0]  md;
    logic        bsy;
    logic [3:0]  sr;
    logic [2:0]  gid;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic mv, input logic [7:0] md, input logic bsy,
                              input logic [3:0] sr, input logic [2:0] gid);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.mv = mv; r.md = md; r.bsy = bsy; r.sr = sr; r.gid = gid;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [7:0] exp_q[$]);
    chk({nm, "_len"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), {24'h0, mon_q[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
  endtask

  vec_t       tbl[21];
  logic [7:0] exp_q[$];
  logic       acc;
  int         idx;
  logic [7:0] bp_bytes[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // contention: req1 (A1,A2) and req3 (B1,B2) together, pointer at 0
    tbl[0]  = mk(4'b1010, 4'b0000, 32'hB1_00_A1_00, 0, 8'h00, 0, 4'b0000, 3'd0);
    tbl[1]  = mk(4'b1010, 4'b0000, 32'hB1_00_A1_00, 0, 8'h00, 1, 4'b0010, 3'd1);
    tbl[2]  = mk(4'b1010, 4'b0010, 32'hB1_00_A2_00, 1, 8'hA1, 1, 4'b0010, 3'd1);
    tbl[3]  = mk(4'b1000, 4'b0000, 32'hB1_00_00_00, 1, 8'hA2, 0, 4'b0000, 3'd1);
    tbl[4]  = mk(4'b1000, 4'b0000, 32'hB1_00_00_00, 0, 8'h00, 1, 4'b1000, 3'd3);
    tbl[5]  = mk(4'b1000, 4'b1000, 32'hB2_00_00_00, 1, 8'hB1, 1, 4'b1000, 3'd3);
    tbl[6]  = mk(4'b0000, 4'b0000, 32'h00_00_00_00, 1, 8'hB2, 0, 4'b0000, 3'd3);
    tbl[7]  = mk(4'b0000, 4'b0000, 32'h00_00_00_00, 0, 8'h00, 0, 4'b0000, 3'd3);
    // req0 packet 11,22,33; req3 also waiting with tlast high (ignored until granted);
    // req0 wins from pointer 0
    tbl[8]  = mk(4'b1001, 4'b1000, 32'hC1_00_00_11, 0, 8'h00, 0, 4'b0000, 3'd3);
    tbl[9]  = mk(4'b1001, 4'b1000, 32'hC1_00_00_11, 0, 8'h00, 1, 4'b0001, 3'd0);
    tbl[10] = mk(4'b1001, 4'b1000, 32'hC1_00_00_22, 1, 8'h11, 1, 4'b0001, 3'd0);
    tbl[11] = mk(4'b1001, 4'b1001, 32'hC1_00_00_33, 1, 8'h22, 1, 4'b0001, 3'd0);
    tbl[12] = mk(4'b1000, 4'b1000, 32'hC1_00_00_00, 1, 8'h33, 0, 4'b0000, 3'd0);
    tbl[13] = mk(4'b1000, 4'b1000, 32'hC1_00_00_00, 0, 8'h00, 1, 4'b1000, 3'd3);
    tbl[14] = mk(4'b0000, 4'b0000, 32'h00_00_00_00, 1, 8'hC1, 0, 4'b0000, 3'd3);
    tbl[15] = mk(4'b0000, 4'b0000, 32'h00_00_00_00, 0, 8'h00, 0, 4'b0000, 3'd3);
    // single active requester, back-to-back one-byte packets
    tbl[16] = mk(4'b0001, 4'b0001, 32'h00_00_00_44, 0, 8'h00, 0, 4'b0000, 3'd3);
    tbl[17] = mk(4'b0001, 4'b0001, 32'h00_00_00_44, 0, 8'h00, 1, 4'b0001, 3'd0);
    tbl[18] = mk(4'b0001, 4'b0001, 32'h00_00_00_55, 1, 8'h44, 0, 4'b0000, 3'd0);
    tbl[19] = mk(4'b0001, 4'b0001, 32'h00_00_00_55, 0, 8'h00, 1, 4'b0001, 3'd0);
    tbl[20] = mk(4'b0000, 4'b0000, 32'h00_00_00_00, 1, 8'h55, 0, 4'b0000, 3'd0);

    rst = 1'b1;
    m_tready = 1'b1;
    idle_in();
    #3;
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_mdata", m_tdata, 8'h00);
    chk("rst_sready", s_tready, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 3'd0);
    next_cyc();
    next_cyc();
    rst = 1'b0;

`ifndef UART_ARB_HDR_EN
    // ---- table ----
    mon_q.delete();
    for (int i = 0; i < 21; i++) begin
      s_tvalid = tbl[i].v;
      s_tlast  = tbl[i].l;
      s_tdata  = tbl[i].d;
      m_tready = 1'b1;
      #3;
      chk($sformatf("row%0d_mvalid", i), m_tvalid, tbl[i].mv);
      if (tbl[i].mv) chk($sformatf("row%0d_mdata", i), m_tdata, tbl[i].md);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("row%0d_sready", i), s_tready, tbl[i].sr);
      chk($sformatf("row%0d_gid", i), grant_id, tbl[i].gid);
      next_cyc();
    end
    idle_in();
    next_cyc();
    exp_q = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'h11, 8'h22, 8'h33, 8'hC1, 8'h44, 8'h55};
    chk_q("table_stream", exp_q);

    // ---- backpressure: req1 sends 61..64, m_tready low for 5 cycles ----
    mon_q.delete();
    bp_bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      m_tready = !(c >= 4 && c < 9);
      s_tvalid = 4'b0010;
      s_tdata  = {16'h0, bp_bytes[idx], 8'h0};
      s_tlast  = (idx == 3) ? 4'b0010 : 4'b0000;
      #3;
      if (!m_tready) begin
        chk($sformatf("bp_hold_c%0d", c), m_tdata, 8'h63);
        chk($sformatf("bp_sready_c%0d", c), s_tready, 4'b0000);
      end
      acc = s_tready[1];
      next_cyc();
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    idle_in();
    m_tready = 1'b1;
    next_cyc();
    next_cyc();
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    chk_q("bp_stream", exp_q);

    // ---- stall: req3 granted, drops valid 10 cycles while req2 waits ----
    mon_q.delete();
    s_tvalid = 4'b1000; s_tdata = 32'h71_00_00_00; s_tlast = 4'b0000;
    #3; chk("stall_idle_busy", busy, 0);
    next_cyc();
    #3; chk("stall_gid", grant_id, 3'd3); chk("stall_sready", s_tready, 4'b1000);
    next_cyc();
    for (int c = 0; c < 10; c++) begin
      s_tvalid = 4'b0100; s_tdata = 32'h00_81_00_00; s_tlast = 4'b0100;
      #3;
      chk($sformatf("stall_hold_gid_c%0d", c), grant_id, 3'd3);
      chk($sformatf("stall_hold_busy_c%0d", c), busy, 1);
      chk($sformatf("stall_req2_c%0d", c), s_tready[2], 0);
      next_cyc();
    end
    s_tvalid = 4'b1100; s_tdata = 32'h72_81_00_00; s_tlast = 4'b1100;
    #3; chk("stall_last_sready", s_tready, 4'b1000);
    next_cyc();
    s_tvalid = 4'b0100; s_tdata = 32'h00_81_00_00; s_tlast = 4'b0100;
    #3; chk("stall_gap_busy", busy, 0);
    next_cyc();
    #3; chk("stall_req2_gid", grant_id, 3'd2); chk("stall_req2_sready", s_tready, 4'b0100);
    next_cyc();
    idle_in();
    next_cyc();
    next_cyc();
    exp_q = '{8'h71, 8'h72, 8'h81};
    chk_q("stall_stream", exp_q);

    // ---- reset during byte 2 of 4 from req1 (pointer is 3 beforehand) ----
    mon_q.delete();
    s_tvalid = 4'b0010; s_tdata = 32'h00_00_91_00; s_tlast = 4'b0000;
    next_cyc();
    next_cyc();
    s_tdata = 32'h00_00_92_00;
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_mvalid", m_tvalid, 0);
    chk("mrst_mdata", m_tdata, 8'h00);
    chk("mrst_sready", s_tready, 4'b0000);
    chk("mrst_busy", busy, 0);
    chk("mrst_gid", grant_id, 3'd0);
    idle_in();
    next_cyc();
    next_cyc();
    rst = 1'b0;
    // req0 and req3 together: req0 first only if the pointer went back to 0
    s_tvalid = 4'b1001; s_tdata = 32'hB5_00_00_A5; s_tlast = 4'b1001;
    #3; chk("post_rst_busy", busy, 0);
    next_cyc();
    #3; chk("post_rst_gid", grant_id, 3'd0); chk("post_rst_sready", s_tready, 4'b0001);
    next_cyc();
    s_tvalid = 4'b1000; s_tlast = 4'b1000;
    next_cyc();
    #3; chk("post_rst_gid3", grant_id, 3'd3);
    next_cyc();
    idle_in();
    next_cyc();
    next_cyc();
    exp_q = '{8'hA5, 8'hB5};
    chk_q("rst_stream", exp_q);
`endif

    // ---- req2 single byte 0x55 (tag byte precedes it in the tag build) ----
    mon_q.delete();
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      s_tvalid = 4'b0100; s_tdata = 32'h00_55_00_00; s_tlast = 4'b0100;
      #3;
      acc = s_tready[2];
      if (acc) chk("hdr_gid", grant_id, 3'd2);
      next_cyc();
    end
    chk("hdr_accepted", acc, 1);
    idle_in();
    next_cyc();
    next_cyc();
    next_cyc();
`ifdef UART_ARB_HDR_EN
    exp_q = '{8'hA2, 8'h55};
`else
    exp_q = '{8'h55};
`endif
    chk_q("hdr_stream", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
